// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage with operand forwarding, single-cycle ALU and
// an iterative shift-add multiplier (32 steps), feeding the EX/MEM register.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reg_read1_in/reg_read2_in      rs / rt operand values from ID/EX
//   immediate_in                   sign-extended immediate from ID/EX
//   rs_in, rt_in, rd_in            register specifiers
//   alu_op_in, reg_dst_in, mem_to_reg_in, alu_src_in,
//   mem_write_in, mem_read_in, reg_write_in   ID/EX control
//   wb_reg_write, wb_rd, wb_data   MEM/WB writeback bus (forwarding source)
//   alu_result_out, write_data_out, dest_reg_out, mem_to_reg_out,
//   mem_write_out, mem_read_out, reg_write_out   EX/MEM register
//   stall_out                      combinational; freezes PC, IF/ID, ID/EX
module ex_stage_mdu #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] reg_read1_in,
   input  logic [DATA_W-1:0] reg_read2_in,
   input  logic [DATA_W-1:0] immediate_in,
   input  logic [4:0]        rs_in,
   input  logic [4:0]        rt_in,
   input  logic [4:0]        rd_in,
   input  logic [2:0]        alu_op_in,
   input  logic [1:0]        reg_dst_in,
   input  logic [1:0]        mem_to_reg_in,
   input  logic              alu_src_in,
   input  logic              mem_write_in,
   input  logic              mem_read_in,
   input  logic              reg_write_in,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] write_data_out,
   output logic [4:0]        dest_reg_out,
   output logic [1:0]        mem_to_reg_out,
   output logic              mem_write_out,
   output logic              mem_read_out,
   output logic              reg_write_out,
   output logic              stall_out
);

   localparam logic [2:0] OP_MUL = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_p1, state_n;
   logic [DATA_W-1:0]  fwd_a, fwd_b, alu_b;
   logic signed [DATA_W-1:0] op_a, op_b, alu_res;
   logic [4:0]         dest_sel;

   // multiplier working registers, captured when the mul starts
   logic [DATA_W-1:0]  mcand_p1, mplier_p1, acc_p1, hold_wd_p1;
   logic [5:0]         cnt_p1;
   logic [4:0]         hold_dest_p1;
   logic [1:0]         hold_m2r_p1;
   logic               hold_mw_p1, hold_mr_p1, hold_rw_p1;

   // EX/MEM has priority; a load in EX/MEM has no data yet, so it is skipped
   function automatic logic [DATA_W-1:0] forward(
      input logic [4:0] src, input logic [DATA_W-1:0] rf_val,
      input logic ex_rw, input logic ex_mr, input logic [4:0] ex_dst,
      input logic [DATA_W-1:0] ex_val, input logic w_rw, input logic [4:0] w_rd,
      input logic [DATA_W-1:0] w_val);
      if (ex_rw && !ex_mr && ex_dst != 5'd0 && ex_dst == src)
         forward = ex_val;
      else if (w_rw && w_rd != 5'd0 && w_rd == src)
         forward = w_val;
      else
         forward = rf_val;
   endfunction

   always_comb begin
      fwd_a = forward(rs_in, reg_read1_in, reg_write_out, mem_read_out, dest_reg_out,
                      alu_result_out, wb_reg_write, wb_rd, wb_data);
      fwd_b = forward(rt_in, reg_read2_in, reg_write_out, mem_read_out, dest_reg_out,
                      alu_result_out, wb_reg_write, wb_rd, wb_data);
      alu_b = alu_src_in ? immediate_in : fwd_b;
      op_a  = fwd_a;
      op_b  = alu_b;
   end

   always_comb begin
      alu_res = '0;
      case (alu_op_in)
         3'b000:  alu_res = op_a + op_b;
         3'b001:  alu_res = op_a - op_b;
         3'b010:  alu_res = op_a & op_b;
         3'b011:  alu_res = op_a | op_b;
         3'b100:  alu_res = (op_a < op_b) ? DATA_W'(1) : '0;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      dest_sel = 5'd0;
      case (reg_dst_in)
         2'b00:   dest_sel = rt_in;
         2'b01:   dest_sel = rd_in;
         2'b10:   dest_sel = 5'd31;
         default: dest_sel = 5'd0;
      endcase
   end

   // FSM next state and stall; stall is forced low while in reset
   always_comb begin
      state_n   = state_p1;
      stall_out = 1'b0;
      case (state_p1)
         IDLE: if (alu_op_in == OP_MUL) begin
            stall_out = 1'b1;
            state_n   = BUSY;
         end
         BUSY: begin
            stall_out = 1'b1;
            if (cnt_p1 == 6'd31) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (rst) stall_out = 1'b0;
   end

   // ---- EX -> EX/MEM stage boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1       <= IDLE;
         mcand_p1       <= '0;
         mplier_p1      <= '0;
         acc_p1         <= '0;
         cnt_p1         <= '0;
         hold_wd_p1     <= '0;
         hold_dest_p1   <= '0;
         hold_m2r_p1    <= '0;
         hold_mw_p1     <= 1'b0;
         hold_mr_p1     <= 1'b0;
         hold_rw_p1     <= 1'b0;
         alu_result_out <= '0;
         write_data_out <= '0;
         dest_reg_out   <= '0;
         mem_to_reg_out <= '0;
         mem_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         reg_write_out  <= 1'b0;
      end else begin
         state_p1 <= state_n;
         // default EX/MEM content is a bubble; overridden below
         alu_result_out <= '0;
         write_data_out <= '0;
         dest_reg_out   <= '0;
         mem_to_reg_out <= '0;
         mem_write_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         reg_write_out  <= 1'b0;
         case (state_p1)
            IDLE: begin
               if (alu_op_in == OP_MUL) begin
                  mcand_p1     <= fwd_a;
                  mplier_p1    <= alu_b;
                  acc_p1       <= '0;
                  cnt_p1       <= '0;
                  hold_wd_p1   <= fwd_b;
                  hold_dest_p1 <= dest_sel;
                  hold_m2r_p1  <= mem_to_reg_in;
                  hold_mw_p1   <= mem_write_in;
                  hold_mr_p1   <= mem_read_in;
                  hold_rw_p1   <= reg_write_in;
               end else begin
                  alu_result_out <= alu_res;
                  write_data_out <= fwd_b;
                  dest_reg_out   <= dest_sel;
                  mem_to_reg_out <= mem_to_reg_in;
                  mem_write_out  <= mem_write_in;
                  mem_read_out   <= mem_read_in;
                  reg_write_out  <= reg_write_in;
               end
            end
            BUSY: begin
               if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
               mcand_p1  <= mcand_p1 << 1;
               mplier_p1 <= mplier_p1 >> 1;
               cnt_p1    <= cnt_p1 + 6'd1;
            end
            DONE: begin
               alu_result_out <= acc_p1;
               write_data_out <= hold_wd_p1;
               dest_reg_out   <= hold_dest_p1;
               mem_to_reg_out <= hold_m2r_p1;
               mem_write_out  <= hold_mw_p1;
               mem_read_out   <= hold_mr_p1;
               reg_write_out  <= hold_rw_p1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage_mdu.sv
module tb_ex_stage_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] reg_read1_in, reg_read2_in, immediate_in;
   logic [4:0]  rs_in, rt_in, rd_in;
   logic [2:0]  alu_op_in;
   logic [1:0]  reg_dst_in, mem_to_reg_in;
   logic        alu_src_in, mem_write_in, mem_read_in, reg_write_in;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] alu_result_out, write_data_out;
   logic [4:0]  dest_reg_out;
   logic [1:0]  mem_to_reg_out;
   logic        mem_write_out, mem_read_out, reg_write_out, stall_out;

   ex_stage_mdu #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .reg_read1_in(reg_read1_in), .reg_read2_in(reg_read2_in),
      .immediate_in(immediate_in),
      .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
      .alu_op_in(alu_op_in), .reg_dst_in(reg_dst_in),
      .mem_to_reg_in(mem_to_reg_in), .alu_src_in(alu_src_in),
      .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
      .reg_write_in(reg_write_in),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .alu_result_out(alu_result_out), .write_data_out(write_data_out),
      .dest_reg_out(dest_reg_out), .mem_to_reg_out(mem_to_reg_out),
      .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
      .reg_write_out(reg_write_out), .stall_out(stall_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] wd;
      logic [4:0]  dest;
      logic [1:0]  m2r;
      logic        mw;
      logic        mr;
      logic        rw;
   } exm_t;

   exm_t exp_q[$];
   exm_t model_exm;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string nm, input logic [74:0] act, input logic [74:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // monitor: EX/MEM is compared after every edge against the scoreboard
   always @(posedge clk) begin
      exm_t e, g;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = '{alu_result_out, write_data_out, dest_reg_out, mem_to_reg_out,
               mem_write_out, mem_read_out, reg_write_out};
         check("exmem", g, e);
      end
   end

   // reference model pieces
   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
      if (model_exm.rw && !model_exm.mr && model_exm.dest != 0 && model_exm.dest == r)
         return model_exm.res;
      if (wb_reg_write && wb_rd != 0 && wb_rd == r) return wb_data;
      return rf;
   endfunction

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd5: return a * b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [4:0] dsel(input logic [1:0] d, input logic [4:0] rt, input logic [4:0] rd);
      case (d)
         2'd0: return rt;
         2'd1: return rd;
         2'd2: return 5'd31;
         default: return 5'd0;
      endcase
   endfunction

   task automatic set_instr(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic src, input logic [1:0] dst,
                            input logic [1:0] m2r, input logic mw, input logic mr, input logic rw);
      alu_op_in = op; rs_in = rs; rt_in = rt; rd_in = rd;
      reg_read1_in = r1; reg_read2_in = r2; immediate_in = imm;
      alu_src_in = src; reg_dst_in = dst; mem_to_reg_in = m2r;
      mem_write_in = mw; mem_read_in = mr; reg_write_in = rw;
   endtask

   task automatic expect_push(input exm_t e);
      exp_q.push_back(e);
      model_exm = e;
   endtask

   // executes the instruction currently on the inputs; called at a negedge,
   // returns at a later negedge. abort_at >= 0 pulses rst on that BUSY cycle.
   task automatic exec(input int abort_at);
      logic [31:0] fa, fb, b;
      exm_t e;
      fa = fwd(rs_in, reg_read1_in);
      fb = fwd(rt_in, reg_read2_in);
      b  = alu_src_in ? immediate_in : fb;
      e  = '{alu(alu_op_in, fa, b), fb, dsel(reg_dst_in, rt_in, rd_in),
             mem_to_reg_in, mem_write_in, mem_read_in, reg_write_in};
      #1;
      if (alu_op_in != 3'd5) begin
         check("stall_single", 75'(stall_out), 75'(0));
         expect_push(e);
         @(negedge clk);
         return;
      end
      check("stall_mul_start", 75'(stall_out), 75'(1));
      expect_push('0);
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         // operand and writeback changes during the multiply must not matter
         wb_reg_write = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
         reg_read1_in = $urandom; reg_read2_in = $urandom; immediate_in = $urandom;
         if (k == abort_at) begin
            rst = 1'b1;
            #1 check("stall_in_rst", 75'(stall_out), 75'(0));
            expect_push('0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         #1 check("stall_mul_busy", 75'(stall_out), 75'(1));
         expect_push('0);
         @(negedge clk);
      end
      #1 check("stall_mul_done", 75'(stall_out), 75'(0));
      expect_push(e);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      wb_reg_write = 0; wb_rd = 0; wb_data = 0;
      set_instr(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_exm = '0;
      @(negedge clk);
      #1 check("stall_rst", 75'(stall_out), 75'(0));
      expect_push('0);
      @(negedge clk);
      rst = 1'b0;

      // add 5+7 -> r9
      set_instr(3'd0, 1, 2, 9, 5, 7, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      // add producing r3 = 12, then sub r3-r3 with stale register reads
      set_instr(3'd0, 1, 2, 3, 5, 7, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      set_instr(3'd1, 3, 3, 6, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      // r4 = 50 in EX/MEM while writeback also offers r4 = 100
      set_instr(3'd0, 1, 2, 4, 20, 30, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      wb_reg_write = 1; wb_rd = 4; wb_data = 100;
      set_instr(3'd3, 4, 0, 7, 1, 0, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      // r0 is never forwarded
      wb_rd = 0; wb_data = 32'hDEAD;
      set_instr(3'd0, 0, 0, 8, 77, 3, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      wb_reg_write = 0;
      // slt, and, reg_dst 10/11, immediate operand
      set_instr(3'd4, 1, 2, 5, 32'hFFFFFFFF, 1, 0, 0, 2'b10, 1, 0, 0, 1); exec(-1);
      set_instr(3'd2, 1, 2, 5, 32'hF0F0, 32'h0FF0, 0, 0, 2'b11, 2, 1, 0, 0); exec(-1);
      set_instr(3'd0, 1, 2, 5, 32'h7FFFFFFF, 0, 32'd1, 1, 2'b00, 0, 0, 1, 1); exec(-1);
      set_instr(3'd6, 1, 2, 5, 9, 9, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      // mul -3 * 7
      set_instr(3'd5, 1, 2, 10, 32'hFFFFFFFD, 7, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      // back-to-back mul: 0x10000 * 0x10000 overflows to 0
      set_instr(3'd5, 1, 2, 11, 32'h10000, 0, 32'h10000, 1, 2'b01, 0, 0, 0, 1); exec(-1);
      // reset during BUSY, then a full mul
      set_instr(3'd5, 1, 2, 12, 32'd123, 32'd456, 0, 0, 2'b01, 0, 0, 0, 1); exec(10);
      set_instr(3'd5, 1, 2, 12, 32'd123, 32'd456, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);
      set_instr(3'd1, 12, 0, 13, 0, 32'd8, 0, 0, 2'b01, 0, 0, 0, 1); exec(-1);

      // random mix with narrow register range to exercise forwarding
      for (int n = 0; n < 150; n++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if (op == 3'd5 && $urandom_range(0, 2) != 0) op = 3'd0;
         wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
         set_instr(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, 1'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
         exec(-1);
      end

      #2;
      check("queue_drained", 75'(exp_q.size()), 75'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
